// File: rtl/upsample_pkg.sv
// Shared types and helpers for the upsample scheduler.
// State encoding, data width and ratio legality check.
package upsample_pkg;

  localparam int US_IL  = 4;
  localparam int US_FL  = 16;
  localparam int DATA_W = US_IL + US_FL;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE,
    S_ERR
  } state_e;

  // Legal ratio: integer-only, nonzero power of two.
  function automatic logic ratio_ok(
    input logic [31:0] int_part,
    input logic        frac_nz
  );
    return (int_part != 32'd0) &&
           ((int_part & (int_part - 32'd1)) == 32'd0) &&
           !frac_nz;
  endfunction

endpackage

// File: rtl/upsample_watchdog.sv
// Run-phase watchdog for the upsample datapath.
// Counts enabled cycles; flags the cycle the count reaches MAX_RUN.
module upsample_watchdog #(
  parameter int MAX_RUN = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(MAX_RUN + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(MAX_RUN))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q == CW'(MAX_RUN - 1));

endmodule

// File: rtl/upsample_scheduler.sv
// Job sequencer for the upsample interpolation datapath.
// Fetches, runs and stores one tile at a time over a job.
module upsample_scheduler
  import upsample_pkg::*;
#(
  parameter int IL      = US_IL,
  parameter int FL      = US_FL,
  parameter int SIZE    = 4,
  parameter int AW      = 16,
  parameter int TW      = 8,
  parameter int MAX_RUN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_src_addr,
  input  logic [AW-1:0]    cfg_dst_addr,
  input  logic [TW-1:0]    cfg_tiles,
  input  logic [IL+FL-1:0] cfg_ratio,
  output logic             rd_req,
  output logic [AW-1:0]    rd_addr,
  input  logic             rd_gnt,
  output logic             wr_req,
  output logic [AW-1:0]    wr_addr,
  input  logic             wr_gnt,
  output logic             us_en,
  output logic             us_input_ready,
  output logic [IL+FL-1:0] us_k,
  input  logic             us_done,
  output logic             busy,
  output logic             job_done,
  output logic             err
);

  localparam int DW = IL + FL;

  if (SIZE < 1) begin : g_size_chk
    $error("SIZE must be positive");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [TW-1:0] tiles_q, tiles_d;
  logic [DW-1:0] ratio_q, ratio_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          wd_clr;
  logic          wd_en;
  logic          wd_exp;
  logic          cfg_ok;
  logic [IL-1:0] k_int;

  assign k_int  = ratio_q[DW-1:FL];
  assign cfg_ok = ratio_ok(32'(cfg_ratio[DW-1:FL]),
                           |cfg_ratio[FL-1:0]) &&
                  (cfg_tiles != '0);
  assign wd_clr = (state_q == S_LOAD);
  assign wd_en  = (state_q == S_RUN);

  upsample_watchdog #(
    .MAX_RUN (MAX_RUN)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_exp)
  );

  // Next state, job latches and Moore outputs.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    tiles_d        = tiles_q;
    ratio_d        = ratio_q;
    cnt_d          = cnt_q;
    cfg_ready      = 1'b0;
    rd_req         = 1'b0;
    rd_addr        = '0;
    wr_req         = 1'b0;
    wr_addr        = '0;
    us_en          = 1'b0;
    us_input_ready = 1'b0;
    job_done       = 1'b0;
    err            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          src_d   = cfg_src_addr;
          dst_d   = cfg_dst_addr;
          tiles_d = cfg_tiles;
          ratio_d = cfg_ratio;
          cnt_d   = '0;
          state_d = cfg_ok ? S_FETCH : S_ERR;
        end
      end
      S_FETCH: begin
        rd_req  = 1'b1;
        rd_addr = src_q + AW'(cnt_q);
        if (rd_gnt) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        us_en          = 1'b1;
        us_input_ready = 1'b1;
        state_d        = S_RUN;
      end
      S_RUN: begin
        us_en = 1'b1;
        if (us_done) begin
          state_d = S_STORE;
        end else if (wd_exp) begin
          state_d = S_ERR;
        end
      end
      S_STORE: begin
        wr_req  = 1'b1;
        wr_addr = dst_q + AW'(cnt_q) * AW'(k_int);
        if (wr_gnt) begin
          cnt_d   = cnt_q + TW'(1);
          state_d = (cnt_q == tiles_q - TW'(1)) ?
                    S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      tiles_q <= '0;
      ratio_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tiles_q <= tiles_d;
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign us_k = ratio_q;

endmodule
